data_memory_mc: RTL
===================

Name: data_memory_mc

Overview:
- Clocked, parametrised successor to the single-cycle MIPS data memory.
- Adds byte, halfword and word loads/stores, sign or zero extension on loads, and a configurable wait-state count.
- Uses a request/ready handshake so the pipeline can stall.
- Sits between the EX/MEM stage and the MEM/WB register; `ready` drives the pipeline stall logic.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
- WAIT_STATES, 1, extra cycles per access; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- address  input  32  byte address of the access.
- write_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- MemWrite  input  1  store request.
- MemRead  input  1  load request.
- size  input  2  access size: 00 byte, 01 half, 10 word; 11 reserved.
- unsigned_ld  input  1  1 = zero-extend loads (lbu/lhu); 0 = sign-extend.
- read_data  output  32  load result, extended to 32 bits.
- ready  output  1  one-cycle pulse marking access completion.
- busy  output  1  high while an access is in flight.
- addr_error  output  1  one-cycle pulse, concurrent with ready, for a rejected access.

Behaviour:
- Reset, asynchronous:
  - state to IDLE, wait counter to 0.
  - read_data, ready, busy, addr_error all 0.
  - Memory array is not cleared.
- FSM states:
  - IDLE: accept a request when MemRead|MemWrite is sampled high at the clk edge. Go to WAIT if WAIT_STATES>0, else go to ACCESS.
  - WAIT: counter counts 1..WAIT_STATES, then go to ACCESS.
  - ACCESS: perform the read or write, pulse ready, return to IDLE.
- Request capture:
  - address, write_data, size, unsigned_ld and op are captured at acceptance.
  - Later changes to inputs do not affect the in-flight access.
- MemRead and MemWrite both high: treated as a write.
- busy = (state != IDLE). Requests arriving while busy are ignored; they are not queued.
- Latency: ready is high in the (WAIT_STATES+1)th cycle after the accept edge.
  - WAIT_STATES=0: ready in the cycle after acceptance.
  - Back-to-back accesses are possible: a request held high in the ready cycle is accepted at the next edge.
- Addressing:
  - Word index = address[log2(DEPTH_WORDS)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Byte lanes are little-endian: lane = address[1:0].
- Stores:
  - Only the addressed lanes are written: byte to lane address[1:0]; half to lanes {address[1],0}/+1; word to all four.
  - Unaddressed lanes keep their value.
- Loads:
  - Extract the addressed byte/half; sign- or zero-extend it per the captured unsigned_ld.
  - read_data updates in the ACCESS cycle and holds until the next completed load.
  - Stores do not modify read_data.
- size = 11: access is rejected. addr_error pulses with ready; no memory write; read_data unchanged.
- Reset mid-access: the access is aborted; a pending store does not modify memory.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: a misaligned access is rejected.
  - Misaligned means a half with address[0]=1, or a word with address[1:0]!=0.
  - Rejection pulses addr_error with ready; no write; read_data unchanged.
- Undefined:
  - Misaligned low address bits are forced to zero: half ignores address[0], word ignores address[1:0].
  - addr_error fires only for size=11.

Test Plan:
- WAIT_STATES=2: sw 0x11223344 @0x0, then lw @0x0. Each ready appears 3 cycles after accept; read_data=0x11223344; busy high for exactly 3 cycles.
- sb 0xAB @0x5 over word 0xFFFFFFFF @0x4, then lw @0x4 -> 0xFFFFABFF. Then lb @0x5 -> 0xFFFFFFAB; lbu @0x5 -> 0x000000AB.
- sh 0x8001 @0x8, then lh @0x8 -> 0xFFFF8001 and lhu @0x8 -> 0x00008001. Request pulsed while busy is ignored: no second ready.
- DEPTH_WORDS=256: sw 0xCAFEBABE @0x400, then lw @0x0 -> 0xCAFEBABE (wrap-around). MemRead and MemWrite both high -> write performed.
- Assert reset during WAIT of sw 0x12345678 @0xC, where the word holds 0x0. Outputs go to 0 immediately; a subsequent lw @0xC -> 0x00000000.
- size=11 -> addr_error and ready pulse together, memory unchanged. With DMEM_ALIGN_CHECK_EN: lw @0x2 -> addr_error. Without it: lw @0x2 returns word @0x0.

Source files
------------

// File: rtl/data_memory_mc.sv
// ----------------------------------------------------------------------------
// data_memory_mc
// Multi-cycle data memory for the MEM stage. Supports byte / halfword / word
// loads and stores with sign or zero extension, a parametrised number of wait
// states and a request / ready handshake that the pipeline uses to stall.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   -> misaligned half / word accesses are rejected (addr_error)
//   undefined -> misaligned low address bits are forced to zero
//
// Timing: the memory operation itself (store or load) takes effect on the
// clock edge that enters the ACCESS state, so read_data is already valid in
// the cycle where ready is high. A request still held in the ready cycle is
// accepted on the edge that leaves ACCESS (back-to-back accesses).
// ----------------------------------------------------------------------------
module data_memory_mc #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        addr_error
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0] WS_CNT   = WAIT_STATES[3:0];

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_ACCESS = 2'b10
  } state_t;

  // --------------------------------------------------------------------------
  // Extension helpers for loads
  // --------------------------------------------------------------------------
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
    ext_byte = {{24{(~uns) & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
    ext_half = {{16{(~uns) & h[15]}}, h};
  endfunction

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_cnt;

  // captured request
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic          r_we;

  // operation fields actually used by the access
  logic [AW+1:0] w_op_addr;
  logic [31:0]   w_op_wdata;
  logic [1:0]    w_op_size;
  logic          w_op_unsigned;
  logic          w_op_we;

  logic          w_req;
  logic          w_accept;
  logic          w_do_access;
  logic          w_size_err;
  logic          w_misalign;
  logic          w_err;
  logic          w_wr_en;
  logic          w_rd_en;

  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes;
  logic [31:0]   w_rword;
  logic [7:0]    w_rbyte;
  logic [15:0]   w_rhalf;
  logic [31:0]   w_load;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [31:0]   r_read_data;
  logic          r_ready;
  logic          r_busy;
  logic          r_addr_error;

  // upper address bits are intentionally ignored (address wraps)
  logic          w_unused;
  assign w_unused = ^address[31:AW+2];

  assign w_req = MemRead | MemWrite;

  // With no wait states the access happens on the accept edge itself, so the
  // live inputs are used; otherwise the captured copy is used.
  assign w_op_addr     = NO_WAIT ? address[AW+1:0] : r_addr;
  assign w_op_wdata    = NO_WAIT ? write_data      : r_wdata;
  assign w_op_size     = NO_WAIT ? size            : r_size;
  assign w_op_unsigned = NO_WAIT ? unsigned_ld     : r_unsigned;
  assign w_op_we       = NO_WAIT ? MemWrite        : r_we;

  assign w_idx = w_op_addr[AW+1:2];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_ACCESS: begin
        if (w_req) begin
          w_next_state = NO_WAIT ? S_ACCESS : S_WAIT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == WS_CNT) begin
          w_next_state = S_ACCESS;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM control decode: accept, access strobe, rejection, write / read enables
  always_comb begin
    w_accept    = 1'b0;
    w_do_access = 1'b0;
    case (r_state)
      S_IDLE, S_ACCESS: begin
        w_accept    = w_req;
        w_do_access = NO_WAIT & w_req;
      end
      S_WAIT: begin
        w_accept    = 1'b0;
        w_do_access = (r_cnt == WS_CNT);
      end
      default: begin
        w_accept    = 1'b0;
        w_do_access = 1'b0;
      end
    endcase
    w_size_err = (w_op_size == 2'b11);
    w_err      = w_size_err | w_misalign;
    w_wr_en    = w_do_access & w_op_we & ~w_err & ~reset;
    w_rd_en    = w_do_access & ~w_op_we & ~w_err;
  end

  // Alignment check (only active when the feature macro is defined)
  always_comb begin
    w_misalign = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    case (w_op_size)
      SZ_HALF: w_misalign = w_op_addr[0];
      SZ_WORD: w_misalign = (w_op_addr[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
`else
    w_misalign = 1'b0;
`endif
  end

  // Wait-state counter: 1..WAIT_STATES while in WAIT, 0 otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (w_accept && !NO_WAIT) begin
      r_cnt <= 4'd1;
    end else if ((r_state == S_WAIT) && (r_cnt != WS_CNT)) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= 4'd0;
    end
  end

  // Request capture at acceptance so later input changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_we       <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= address[AW+1:0];
      r_wdata    <= write_data;
      r_size     <= size;
      r_unsigned <= unsigned_ld;
      r_we       <= MemWrite;
    end else begin
      r_addr     <= r_addr;
      r_wdata    <= r_wdata;
      r_size     <= r_size;
      r_unsigned <= r_unsigned;
      r_we       <= r_we;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------

  // Store lane enables and lane-replicated store data (little-endian lanes)
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = w_op_wdata;
    case (w_op_size)
      SZ_BYTE: begin
        w_be     = 4'b0001 << w_op_addr[1:0];
        w_wlanes = {4{w_op_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be     = w_op_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_op_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_be     = 4'b1111;
        w_wlanes = w_op_wdata;
      end
      default: begin
        w_be     = 4'b0000;
        w_wlanes = w_op_wdata;
      end
    endcase
  end

  // Memory array write; contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
        end
      end
    end
  end

  assign w_rword = r_mem[w_idx];

  // Load lane extraction and extension
  always_comb begin
    w_rbyte = 8'd0;
    case (w_op_addr[1:0])
      2'b00:   w_rbyte = w_rword[7:0];
      2'b01:   w_rbyte = w_rword[15:8];
      2'b10:   w_rbyte = w_rword[23:16];
      2'b11:   w_rbyte = w_rword[31:24];
      default: w_rbyte = 8'd0;
    endcase
    if (w_op_addr[1]) begin
      w_rhalf = w_rword[31:16];
    end else begin
      w_rhalf = w_rword[15:0];
    end
    w_load = r_read_data;
    case (w_op_size)
      SZ_BYTE: w_load = ext_byte(w_rbyte, w_op_unsigned);
      SZ_HALF: w_load = ext_half(w_rhalf, w_op_unsigned);
      SZ_WORD: w_load = w_rword;
      default: w_load = r_read_data;
    endcase
  end

  // Registered outputs: ready/addr_error mark the ACCESS cycle, busy tracks
  // state != IDLE, read_data changes only on completed loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data  <= 32'd0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_addr_error <= 1'b0;
    end else begin
      r_ready      <= w_do_access;
      r_addr_error <= w_do_access & w_err;
      r_busy       <= (w_next_state != S_IDLE);
      if (w_rd_en) begin
        r_read_data <= w_load;
      end else begin
        r_read_data <= r_read_data;
      end
    end
  end

  assign read_data  = r_read_data;
  assign ready      = r_ready;
  assign busy       = r_busy;
  assign addr_error = r_addr_error;

endmodule
